// File: rtl/zx_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zx_mem_pkg : shared constants and types for the ZX Spectrum memory pager |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package zx_mem_pkg;

  localparam logic [15:0] PORT_7FFD_MASK  = 16'h8002;
  localparam logic [15:0] PORT_7FFD_MATCH = 16'h0000;
  localparam logic [15:0] PORT_1FFD_MASK  = 16'hF002;
  localparam logic [15:0] PORT_1FFD_MATCH = 16'h1000;

  localparam logic [2:0] BANK_SCR0   = 3'd5;
  localparam logic [2:0] BANK_SCR1   = 3'd7;
  localparam logic [2:0] BANK_FIXED2 = 3'd2;

  typedef enum logic [1:0] {
    SPEC_0123 = 2'd0,
    SPEC_4567 = 2'd1,
    SPEC_4563 = 2'd2,
    SPEC_4763 = 2'd3
  } spec_cfg_t;

  // All-RAM +3 layouts, indexed by quadrant A[15:14].
  function automatic logic [2:0] special_bank(spec_cfg_t cfg, logic [1:0] quad);
    logic [2:0] b;
    b = {1'b0, quad};
    case (cfg)
      SPEC_0123: b = {1'b0, quad};
      SPEC_4567: b = {1'b1, quad};
      SPEC_4563: b = (quad == 2'd3) ? 3'd3 : {1'b1, quad};
      default:   b = (quad == 2'd3) ? 3'd3 : (quad == 2'd1) ? 3'd7 : {1'b1, quad};
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zx_io_wr_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zx_io_wr_edge : one-shot load strobe on the first edge of an IO decode   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module zx_io_wr_edge (
  input  logic clk_cpu,
  input  logic nRESET,
  input  logic wr_dec,
  output logic wr_load
);

  logic dec_q;
  logic dec_d;

  always_comb dec_d = wr_dec;

  always_ff @(posedge clk_cpu or negedge nRESET) begin
    if (!nRESET) dec_q <= 1'b0;
    else         dec_q <= dec_d;
  end

  // Wait states keep the decode high; only its rising edge loads.
  assign wr_load = wr_dec && !dec_q;

endmodule
`default_nettype wire

// File: rtl/zx_mem_pager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zx_mem_pager : 7FFD/1FFD paging registers and CPU address translation.   |
// | Optional +3 port 1FFD and special mapping enabled by macro PLUS3_EN.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module zx_mem_pager
  import zx_mem_pkg::*;
#(
  parameter int RAM_BANK_BITS = 3
) (
  input  logic                     clk_cpu,
  input  logic                     nRESET,
  input  logic [15:0]              A,
  input  logic [7:0]               D,
  input  logic                     nMREQ,
  input  logic                     nIORQ,
  input  logic                     nRD,
  input  logic                     nWR,
  input  logic                     nM1,
  output logic [1:0]               rom_page,
  output logic                     is_rom,
  output logic [RAM_BANK_BITS-1:0] ram_bank,
  output logic                     shadow_scr,
  output logic                     scr_we,
  output logic                     paging_locked,
  output logic                     pg_changed
);

  logic io_we;
  logic dec_7ffd, load_7ffd, acc_7ffd, acc_1ffd;
  logic special, rom_hi;
  spec_cfg_t spec_cfg;

  logic [RAM_BANK_BITS-1:0] bank_q, bank_d;
  logic shadow_q, shadow_d, rom_lo_q, rom_lo_d, lock_q, lock_d;
  logic pg_changed_q, pg_changed_d;

  logic [4:0] bank_src;
  logic       unused_bank_src;
  logic [1:0] quad;

  assign io_we    = !nIORQ && !nWR && nM1;
  assign dec_7ffd = io_we && ((A & PORT_7FFD_MASK) == PORT_7FFD_MATCH);

  zx_io_wr_edge u_edge_7ffd (
    .clk_cpu (clk_cpu),
    .nRESET  (nRESET),
    .wr_dec  (dec_7ffd),
    .wr_load (load_7ffd)
  );

  // Lock is sampled from its old value, so a locking write still lands in full.
  assign acc_7ffd = load_7ffd && !lock_q;

`ifdef PLUS3_EN
  logic       dec_1ffd, load_1ffd;
  logic [2:0] p3_q, p3_d;

  assign dec_1ffd = io_we && ((A & PORT_1FFD_MASK) == PORT_1FFD_MATCH);

  zx_io_wr_edge u_edge_1ffd (
    .clk_cpu (clk_cpu),
    .nRESET  (nRESET),
    .wr_dec  (dec_1ffd),
    .wr_load (load_1ffd)
  );

  assign acc_1ffd = load_1ffd && !lock_q;

  always_comb p3_d = acc_1ffd ? D[2:0] : p3_q;

  always_ff @(posedge clk_cpu or negedge nRESET) begin
    if (!nRESET) p3_q <= 3'd0;
    else         p3_q <= p3_d;
  end

  assign special  = p3_q[0];
  assign spec_cfg = spec_cfg_t'(p3_q[2:1]);
  assign rom_hi   = p3_q[2];
`else
  assign acc_1ffd = 1'b0;
  assign special  = 1'b0;
  assign spec_cfg = SPEC_0123;
  assign rom_hi   = 1'b0;
`endif

  // D[6] and D[7] extend the bank number only as far as RAM_BANK_BITS reaches.
  assign bank_src        = {D[7], D[6], D[2:0]};
  assign unused_bank_src = ^bank_src;

  always_comb begin
    bank_d       = bank_q;
    shadow_d     = shadow_q;
    rom_lo_d     = rom_lo_q;
    lock_d       = lock_q;
    if (acc_7ffd) begin
      bank_d   = bank_src[RAM_BANK_BITS-1:0];
      shadow_d = D[3];
      rom_lo_d = D[4];
      lock_d   = D[5];
    end
    pg_changed_d = acc_7ffd || acc_1ffd;
  end

  always_ff @(posedge clk_cpu or negedge nRESET) begin
    if (!nRESET) begin
      bank_q       <= '0;
      shadow_q     <= 1'b0;
      rom_lo_q     <= 1'b0;
      lock_q       <= 1'b0;
      pg_changed_q <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      shadow_q     <= shadow_d;
      rom_lo_q     <= rom_lo_d;
      lock_q       <= lock_d;
      pg_changed_q <= pg_changed_d;
    end
  end

  assign quad = A[15:14];

  always_comb begin
    is_rom   = 1'b0;
    ram_bank = '0;
    if (special) begin
      ram_bank = RAM_BANK_BITS'(special_bank(spec_cfg, quad));
    end else begin
      case (quad)
        2'd0:    is_rom   = 1'b1;
        2'd1:    ram_bank = RAM_BANK_BITS'(BANK_SCR0);
        2'd2:    ram_bank = RAM_BANK_BITS'(BANK_FIXED2);
        default: ram_bank = bank_q;
      endcase
    end
  end

  assign scr_we = !nMREQ && !nWR && nRD && !is_rom &&
                  ((ram_bank == RAM_BANK_BITS'(BANK_SCR0)) ||
                   (ram_bank == RAM_BANK_BITS'(BANK_SCR1)));

  assign rom_page      = {rom_hi, rom_lo_q};
  assign shadow_scr    = shadow_q;
  assign paging_locked = lock_q;
  assign pg_changed    = pg_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_zx_mem_pager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_zx_mem_pager : directed + random bench, 3-bit and 5-bit bank builds   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_zx_mem_pager;

`ifdef PLUS3_EN
  localparam bit PLUS3 = 1'b1;
`else
  localparam bit PLUS3 = 1'b0;
`endif

  logic        clk_cpu, nRESET;
  logic [15:0] A;
  logic [7:0]  D;
  logic        nMREQ, nIORQ, nRD, nWR, nM1;

  logic [1:0] rom_page3, rom_page5;
  logic       is_rom3, is_rom5;
  logic [2:0] ram_bank3;
  logic [4:0] ram_bank5;
  logic       shadow3, shadow5, scr_we3, scr_we5, locked3, locked5, pgc3, pgc5;

  int checks = 0;
  int errors = 0;

  // Reference state: the values last written by an accepted OUT.
  int m_bank, m_cfg;
  bit m_shadow, m_rom_lo, m_lock, m_special, m_rom_hi;

  int          sp_tbl [0:3][0:3];
  logic [15:0] r_a;
  logic [7:0]  r_d;
  bit          acc;
  int          op, sel;

  zx_mem_pager #(.RAM_BANK_BITS(3)) u_dut3 (
    .clk_cpu(clk_cpu), .nRESET(nRESET), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .rom_page(rom_page3), .is_rom(is_rom3), .ram_bank(ram_bank3),
    .shadow_scr(shadow3), .scr_we(scr_we3), .paging_locked(locked3),
    .pg_changed(pgc3)
  );

  zx_mem_pager #(.RAM_BANK_BITS(5)) u_dut5 (
    .clk_cpu(clk_cpu), .nRESET(nRESET), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .rom_page(rom_page5), .is_rom(is_rom5), .ram_bank(ram_bank5),
    .shadow_scr(shadow5), .scr_we(scr_we5), .paging_locked(locked5),
    .pg_changed(pgc5)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_bank = 0; m_cfg = 0;
    m_shadow = 0; m_rom_lo = 0; m_lock = 0; m_special = 0; m_rom_hi = 0;
  endfunction

  function automatic bit model_write(logic [15:0] a, logic [7:0] d);
    bit p7, p1;
    p7 = (a[15] == 1'b0) && (a[1] == 1'b0);
    p1 = PLUS3 && (a[15:12] == 4'h1) && (a[1] == 1'b0);
    if (m_lock || !(p7 || p1)) return 1'b0;
    if (p7) begin
      m_bank   = 16 * d[7] + 8 * d[6] + d[2:0];
      m_shadow = d[3];
      m_rom_lo = d[4];
      m_lock   = d[5];
    end
    if (p1) begin
      m_special = d[0];
      m_cfg     = d[2:1];
      m_rom_hi  = d[2];
    end
    return 1'b1;
  endfunction

  function automatic int exp_bank(int w, logic [15:0] a);
    int q;
    q = a[15:14];
    if (m_special) return sp_tbl[m_cfg][q];
    if (q == 1) return 5;
    if (q == 2) return 2;
    if (q == 3) return m_bank % (1 << w);
    return 0;
  endfunction

  task automatic mem_check(string tag, logic [15:0] a, bit wr);
    bit er;
    int b3, b5;
    @(negedge clk_cpu);
    A = a; nIORQ = 1; nM1 = 1; nMREQ = 0; nRD = wr; nWR = !wr;
    #1;
    er = !m_special && (a[15:14] == 2'd0);
    b3 = exp_bank(3, a);
    b5 = exp_bank(5, a);
    chk({tag, ".is_rom3"}, is_rom3, er);
    chk({tag, ".is_rom5"}, is_rom5, er);
    chk({tag, ".rom_page"}, rom_page3, {m_rom_hi, m_rom_lo});
    if (!er) begin
      chk({tag, ".bank3"}, ram_bank3, b3);
      chk({tag, ".bank5"}, ram_bank5, b5);
    end
    chk({tag, ".scr_we3"}, scr_we3, wr && !er && (b3 == 5 || b3 == 7));
    chk({tag, ".scr_we5"}, scr_we5, wr && !er && (b5 == 5 || b5 == 7));
    chk({tag, ".shadow"}, shadow3, m_shadow);
    chk({tag, ".locked"}, locked5, m_lock);
  endtask

  task automatic io_write(string tag, logic [15:0] a, logic [7:0] d, int hold);
    bit ok;
    @(negedge clk_cpu);
    A = a; D = d; nMREQ = 1; nRD = 1; nM1 = 1; nIORQ = 0; nWR = 0;
    ok = model_write(a, d);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_cpu); #1;
      chk({tag, ".pg3"}, pgc3, ok && (i == 0));
      chk({tag, ".pg5"}, pgc5, ok && (i == 0));
    end
    @(negedge clk_cpu);
    nIORQ = 1; nWR = 1;
    @(posedge clk_cpu); #1;
    chk({tag, ".pg_end"}, pgc3, 1'b0);
    chk({tag, ".locked"}, locked3, m_lock);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk_cpu);
    nRESET = 0; #1;
    model_reset();
    chk({tag, ".locked"}, locked3, 1'b0);
    chk({tag, ".rom_page"}, rom_page5, 2'd0);
    chk({tag, ".pg"}, pgc3, 1'b0);
    @(negedge clk_cpu);
    nRESET = 1;
  endtask

  initial begin
    sp_tbl = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};
    A = 16'h0000; D = 8'h00;
    nMREQ = 1; nIORQ = 1; nRD = 1; nWR = 1; nM1 = 1;
    nRESET = 0;
    model_reset();
    #2;
    chk("rst.pg", pgc5, 1'b0);
    chk("rst.locked", locked3, 1'b0);
    chk("rst.shadow", shadow5, 1'b0);
    @(negedge clk_cpu);
    nRESET = 1;

    mem_check("rst_q0", 16'h0000, 1'b0);
    mem_check("rst_q3", 16'hC000, 1'b0);

    io_write("w17", 16'h7FFD, 8'h17, 1);
    mem_check("w17_rd", 16'hC000, 1'b0);
    mem_check("w17_wr", 16'hC123, 1'b1);
    mem_check("w17_rom", 16'h0100, 1'b0);

    io_write("lock", 16'h7FFD, 8'h20, 1);
    io_write("locked_wr", 16'h7FFD, 8'h03, 1);
    mem_check("locked_q3", 16'hC000, 1'b0);
    do_reset("unlock");
    mem_check("unlocked", 16'hC000, 1'b0);

    io_write("wC1", 16'h7FFD, 8'hC1, 1);
    mem_check("wC1_wr", 16'hC000, 1'b1);

    io_write("w1ffd", 16'h1FFD, 8'h07, 1);
    mem_check("p3_q0", 16'h0000, 1'b0);
    mem_check("p3_q1", 16'h4000, 1'b1);
    mem_check("p3_q2", 16'h8000, 1'b0);
    mem_check("p3_q3", 16'hC000, 1'b1);

    io_write("wait4", 16'h7FFD, 8'h0E, 4);
    mem_check("wait4_q3", 16'hFFFF, 1'b1);

    // Reset pulsed while the write strobe stays active, then released.
    @(negedge clk_cpu);
    A = 16'h7FFD; D = 8'h15; nMREQ = 1; nRD = 1; nM1 = 1; nIORQ = 0; nWR = 0;
    acc = model_write(A, D);
    @(posedge clk_cpu); #1;
    chk("midrst.pg_first", pgc3, acc);
    #2;
    nRESET = 0; #1;
    model_reset();
    chk("midrst.rom_page", rom_page3, 2'd0);
    chk("midrst.pg_clr", pgc5, 1'b0);
    @(negedge clk_cpu);
    nRESET = 1;
    acc = model_write(A, D);
    @(posedge clk_cpu); #1;
    chk("midrst.pg_again", pgc3, acc);
    @(posedge clk_cpu); #1;
    chk("midrst.pg_once", pgc5, 1'b0);
    @(negedge clk_cpu);
    nIORQ = 1; nWR = 1;
    mem_check("midrst_q3", 16'hC000, 1'b1);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        do_reset("rnd_rst");
      end else if (op < 5) begin
        sel = $urandom_range(0, 3);
        r_a = (sel == 0) ? 16'h7FFD : (sel == 1) ? 16'h1FFD : 16'($urandom);
        r_d = 8'($urandom);
        if ($urandom_range(0, 3) != 0) r_d[5] = 1'b0;
        io_write("rnd_io", r_a, r_d, $urandom_range(1, 3));
      end else begin
        mem_check("rnd_mem", 16'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
